// File: rtl/nn_layer_sequencer.sv
// Sequences one neuron-layer evaluation: multiply-accumulates N_INPUTS beats and drives the IN/BUFF/OUT phase FSM pulses.
// Optional build macro NNSEQ_SAT_EN: saturating accumulation instead of two's-complement wrap.
module nn_layer_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int N_INPUTS = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [CNT_W-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              changes,
    output logic              fsm_rst,
    output logic [1:0]        phase,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, OUTPUT} state_t;

    state_t state, next_state;

    logic [ACC_W-1:0]    acc, acc_next;
    logic [CNT_W-1:0]    count;
    logic                accept, last_beat, handshake;
    logic [2*DATA_W-1:0] in_ext, w_ext, prod;
    logic [ACC_W:0]      sum;

    logic              in_ready_d, out_valid_d, changes_d, fsm_rst_d, busy_d;
    logic [1:0]        phase_d;
    logic [ACC_W-1:0]  out_data_d;

    assign accept    = (state == COLLECT) && in_valid && in_ready;
    assign last_beat = (count == CNT_W'(N_INPUTS - 1));
    assign handshake = (state == OUTPUT) && out_valid && out_ready;
    assign w_addr    = count;

    // Operands are sign-extended first so the truncated product is the exact signed result.
    assign in_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_ext  = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    assign prod   = in_ext * w_ext;
    assign sum    = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

`ifdef NNSEQ_SAT_EN
    // One guard bit is enough: a disagreement with the sign bit means the add left the ACC_W range.
    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1])
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COLLECT;
            COLLECT: if (accept && last_beat) next_state = FLUSH;
            FLUSH:   next_state = OUTPUT;
            OUTPUT:  if (handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values are derived from the upcoming state so every port comes straight from a flop.
    always_comb begin
        in_ready_d  = (next_state == COLLECT);
        out_valid_d = (next_state == OUTPUT);
        busy_d      = (next_state != IDLE);
        changes_d   = ((state == COLLECT) && (next_state == FLUSH)) ||
                      ((state == FLUSH) && (next_state == OUTPUT));
        fsm_rst_d   = (state == OUTPUT) && (next_state == IDLE);
        out_data_d  = (state == FLUSH) ? acc : out_data;
        case (next_state)
            FLUSH:   phase_d = 2'b01;
            OUTPUT:  phase_d = 2'b10;
            default: phase_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            changes   <= 1'b0;
            fsm_rst   <= 1'b0;
            phase     <= 2'b00;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            changes   <= changes_d;
            fsm_rst   <= fsm_rst_d;
            phase     <= phase_d;
            busy      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
        end else if ((state == IDLE) && start) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= last_beat ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
Controller that sequences one neuron-layer evaluation. It accepts N_INPUTS input beats and multiply-accumulates each against a weight it addresses. It then presents the result over a valid/ready handshake. It also generates the `changes` pulses and a return-to-IN pulse that drive the IN/BUFF/OUT phase state machine, so that machine always tracks the real datapath phase.

Parameters:
DATA_W, 8, width of signed input and weight samples
ACC_W, 20, width of signed accumulator/result; constraint ACC_W >= 2*DATA_W
N_INPUTS, 4, beats per evaluation; constraint N_INPUTS >= 2
CNT_W, 3, beat counter / weight address width; constraint 2**CNT_W >= N_INPUTS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin evaluation; sampled only in IDLE
in_valid  in  1  input beat valid
in_ready  out  1  sequencer accepts beat
in_data  in  DATA_W  signed input sample
w_addr  out  CNT_W  weight index for the current beat
w_data  in  DATA_W  signed weight for w_addr, same cycle
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  ACC_W  signed accumulated result
changes  out  1  one-cycle phase-advance pulse to the phase FSM
fsm_rst  out  1  one-cycle pulse returning the phase FSM to IN
phase  out  2  sequencer's phase view: 00 IN, 01 BUFF, 10 OUT
busy  out  1  high in any state except IDLE

Behaviour:
- One clock; synchronous active-high reset; all outputs registered.
- Reset values:
  - state=IDLE, acc=0, count=0, w_addr=0.
  - in_ready=0, out_valid=0, out_data=0.
  - changes=0, fsm_rst=0, phase=00, busy=0.
- Reset has priority over all events, including mid-evaluation. The partial accumulation is discarded and no pulses are emitted.
- States: IDLE, COLLECT, FLUSH, OUTPUT.
- IDLE:
  - in_ready=0.
  - start=1 at cycle t -> COLLECT at t+1 with acc=0, count=0, busy=1, in_ready=1.
- COLLECT:
  - A beat is accepted when in_valid & in_ready.
  - On accept: acc += sext(in_data*w_data), count++, w_addr=count.
  - in_valid=0 cycles are bubbles: nothing changes.
  - Accepting beat N_INPUTS-1 at cycle t -> FLUSH at t+1 with in_ready=0, changes=1, phase=01.
- FLUSH:
  - Single cycle -> OUTPUT at t+2 with changes=1, phase=10, out_valid=1, out_data=final acc.
- OUTPUT:
  - out_valid and out_data are held stable until out_ready.
  - Handshake at cycle u -> at u+1: out_valid=0, fsm_rst=1, phase=00, busy=0, state=IDLE.
- changes and fsm_rst are each high for exactly one cycle per event and never high together.
- start outside IDLE is ignored; it is not queued. start in the cycle after a handshake is accepted, giving a minimum of one IDLE cycle between evaluations.
- Arithmetic:
  - Product is signed DATA_W x DATA_W giving 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2**ACC_W unless the optional feature is enabled.
- Latency: result valid 2 cycles after the last accepted beat.

Optional Feature:
NNSEQ_SAT_EN
- Defined: each accumulate saturates to the signed ACC_W range, max 2**(ACC_W-1)-1 and min -2**(ACC_W-1). Once saturated, later beats may pull the value back in range.
- Undefined: two's-complement wrap.

Test Plan:
1. Reset, start=1, then in_data=1,2,3,4 with all weights 1, in_valid continuous, out_ready=1.
   -> w_addr 0..3; changes at last+1 and last+2; phase 00->01->10; out_data=10; fsm_rst one cycle after handshake; phase=00, busy=0.
2. Signed: in_data=-3,7,-128,0 with w_data=5,-2,1,9.
   -> out_data=-157 (0xFFF63 at ACC_W=20).
3. Input bubbles: in_valid toggled 1,0,0,1,1,0,1.
   -> only 4 beats accepted; w_addr and acc hold during bubbles; result matches scenario 1.
4. Backpressure: out_ready=0 for 5 cycles in OUTPUT.
   -> out_valid=1 and out_data constant; no fsm_rst, no changes; handshake on cycle 6.
5. start asserted during COLLECT and OUTPUT is ignored. reset after beat 2 -> all outputs at reset values next cycle. A new start then gives a clean result of 10 with scenario 1 data.
6. ACC_W=16, in_data=127 and w_data=127 for 4 beats.
   -> with NNSEQ_SAT_EN out_data=32767; without it out_data=-1020 (0xFC04).
